// File: rtl/miniscope_emulator_if.sv
// ---------------------------------------------------------------------------
// miniscope_emulator_if
//   Signal bundle between the acquisition side and the miniscope emulator.
//
//   Protocol (no valid/ready pair on this link; it is a level/pulse interface):
//     trig        : level from the acquisition side. A 0->1 transition seen by
//                   the emulator while idle starts a recording session. The
//                   session continues while trig stays high.
//     count_clear : single-cycle pulse. It zeroes frame_count on the next edge.
//     sync        : registered frame-sync pulse train from the emulator.
//     busy        : registered. High while the emulator is in a session.
//     frame_count : registered count of sync rising edges since reset or clear.
//
//   Modports:
//     master : acquisition side (drives trig and count_clear).
//     slave  : emulator (drives sync, busy and frame_count).
// ---------------------------------------------------------------------------
interface miniscope_emulator_if;
  logic        trig;
  logic        count_clear;
  logic        sync;
  logic        busy;
  logic [31:0] frame_count;

  modport master (
    output trig,
    output count_clear,
    input  sync,
    input  busy,
    input  frame_count
  );

  modport slave (
    input  trig,
    input  count_clear,
    output sync,
    output busy,
    output frame_count
  );
endinterface

// File: rtl/miniscope_emulator.sv
// ---------------------------------------------------------------------------
// miniscope_emulator
//   Bench-side stand-in for the head-mounted miniscope. It watches the trig
//   recording enable and answers with a frame-sync pulse train. It also keeps
//   its own frame count.
//
//   Ports:
//     clk       : 1 MHz system clock
//     reset_n   : asynchronous, active-low reset
//     bus       : miniscope_emulator_if.slave (trig, count_clear in;
//                 sync, busy, frame_count out)
//     dbg_state : current FSM state (0 IDLE, 1 STARTUP, 2 FRAME_HIGH,
//                 3 FRAME_LOW)
//
//   Optional feature: define MINISCOPE_EMULATOR_JITTER_EN to add 0-15 clocks
//   of LFSR-driven jitter to every FRAME_LOW phase. The LFSR is a 16-bit
//   Fibonacci generator with taps 16,14,13,11 and seed 16'hACE1.
// ---------------------------------------------------------------------------
module miniscope_emulator #(
  parameter int FRAME_PERIOD  = 50_000,
  parameter int SYNC_HIGH     = 25_000,
  parameter int STARTUP_DELAY = 1_000,
  parameter int CNT_W         = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  miniscope_emulator_if.slave   bus,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STARTUP = 2'd1;
  localparam logic [1:0] S_HIGH    = 2'd2;
  localparam logic [1:0] S_LOW     = 2'd3;

  // Counters are loaded with (length - 1) and expire when they reach zero.
  // This makes a phase of N clocks last exactly N edges.
  localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_DELAY - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD    = CNT_W'(SYNC_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD     = CNT_W'(FRAME_PERIOD - SYNC_HIGH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             trig_q;
  logic             rise_armed;
  logic             sync_r;
  logic             busy_r;
  logic [31:0]      frame_count_r;

  logic             rise;
  logic             cnt_zero;
  logic             frame_start;
  logic             enter_low;
  logic [CNT_W-1:0] low_load;

  // rise_armed is cleared by reset and set on the first edge after release.
  // That first edge therefore counts as entering IDLE: if trig is already
  // high coming out of reset, it is not taken as a fresh rise.
  always_comb begin
    rise        = 1'b0;
    cnt_zero    = (cnt == '0);
    frame_start = 1'b0;
    enter_low   = 1'b0;
    rise        = bus.trig && !trig_q && rise_armed;
    if (state == S_STARTUP && bus.trig && cnt_zero) frame_start = 1'b1;
    if (state == S_LOW && bus.trig && cnt_zero)     frame_start = 1'b1;
    if (state == S_HIGH && cnt_zero)                enter_low   = 1'b1;
  end

`ifdef MINISCOPE_EMULATOR_JITTER_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // The LFSR steps on entry to FRAME_LOW. The stepped value sets that low
  // phase's extra length. A nonzero seed with maximal taps never reaches zero.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign low_load  = LOW_LOAD + {{(CNT_W-4){1'b0}}, lfsr_next[3:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (enter_low) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign low_load = LOW_LOAD;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      trig_q     <= 1'b0;
      rise_armed <= 1'b0;
      sync_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      trig_q     <= bus.trig;
      rise_armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rise) begin
            state  <= S_STARTUP;
            cnt    <= STARTUP_LOAD;
            busy_r <= 1'b1;
          end
        end
        S_STARTUP: begin
          // Dropping trig during startup aborts the session. No pulse is
          // emitted and nothing is counted.
          if (!bus.trig) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
          end else if (cnt_zero) begin
            state  <= S_HIGH;
            cnt    <= HIGH_LOAD;
            sync_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HIGH: begin
          // A frame always runs to completion, whatever trig does meanwhile.
          if (cnt_zero) begin
            state  <= S_LOW;
            cnt    <= low_load;
            sync_r <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (cnt_zero) begin
            if (bus.trig) begin
              state  <= S_HIGH;
              cnt    <= HIGH_LOAD;
              sync_r <= 1'b1;
            end else begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // A clear beats a coincident increment. The count wraps silently at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r <= '0;
    end else if (bus.count_clear) begin
      frame_count_r <= '0;
    end else if (frame_start) begin
      frame_count_r <= frame_count_r + 32'd1;
    end
  end

  assign bus.sync        = sync_r;
  assign bus.busy        = busy_r;
  assign bus.frame_count = frame_count_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_miniscope_emulator.sv
// ---------------------------------------------------------------------------
// tb_miniscope_emulator
//   Directed bench for miniscope_emulator with FRAME_PERIOD=10, SYNC_HIGH=4,
//   STARTUP_DELAY=3. Cycle index 0 is the edge that samples trig's rise.
//   Inputs change 1 ns after a rising edge, and outputs are sampled there.
//   The jitter scenario is built only with MINISCOPE_EMULATOR_JITTER_EN.
// ---------------------------------------------------------------------------
module tb_miniscope_emulator;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  miniscope_emulator_if bus ();

  miniscope_emulator #(
    .FRAME_PERIOD  (10),
    .SYNC_HIGH     (4),
    .STARTUP_DELAY (3),
    .CNT_W         (17)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic        exp_sync;
    logic        exp_busy;
    logic [31:0] exp_cnt;
    int          n;

    checks = 0;
    errors = 0;
    reset_n         = 1'b0;
    bus.trig        = 1'b1;
    bus.count_clear = 1'b0;

    // 1. Reset held with trig high, then release with trig still high.
    repeat (3) begin
      tick();
      check("rst_sync", 32'(bus.sync), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_count", bus.frame_count, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
    end
    reset_n = 1'b1;
    repeat (12) begin
      tick();
      check("held_trig_sync", 32'(bus.sync), 32'd0);
      check("held_trig_busy", 32'(bus.busy), 32'd0);
    end
    bus.trig = 1'b0;
    repeat (3) tick();

    // 2. Four back-to-back frames. trig is first sampled low at index 35,
    //    inside the fourth frame, which still completes. busy drops at 43.
    bus.trig = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 35) bus.trig = 1'b0;
      tick();
      exp_sync = (i >= 3) && (i < 37) && (((i - 3) % 10) < 4);
      exp_busy = (i < 43);
      exp_cnt  = (i >= 33) ? 32'd4 : (i >= 23) ? 32'd3 :
                 (i >= 13) ? 32'd2 : (i >= 3)  ? 32'd1 : 32'd0;
      check("t2_sync", 32'(bus.sync), 32'(exp_sync));
      check("t2_busy", 32'(bus.busy), 32'(exp_busy));
      check("t2_count", bus.frame_count, exp_cnt);
    end
    check("t2_state_idle", 32'(dbg_state), 32'd0);

    // 3. trig high for two clocks only: startup is aborted.
    repeat (2) tick();
    bus.trig = 1'b1;
    tick();
    check("t3_busy_0", 32'(bus.busy), 32'd1);
    check("t3_state_0", 32'(dbg_state), 32'd1);
    tick();
    check("t3_busy_1", 32'(bus.busy), 32'd1);
    bus.trig = 1'b0;
    tick();
    check("t3_busy_2", 32'(bus.busy), 32'd0);
    repeat (10) begin
      tick();
      check("t3_sync", 32'(bus.sync), 32'd0);
      check("t3_count", bus.frame_count, 32'd4);
    end

    // 4. Count 5,6,7, then clear on the edge where the 8th sync rises.
    bus.trig = 1'b1;
    for (int i = 0; i < 46; i++) begin
      bus.count_clear = (i == 33);
      tick();
      exp_sync = (i >= 3) && (((i - 3) % 10) < 4);
      exp_cnt  = (i >= 43) ? 32'd1 : (i >= 33) ? 32'd0 : (i >= 23) ? 32'd7 :
                 (i >= 13) ? 32'd6 : (i >= 3)  ? 32'd5 : 32'd4;
      check("t4_sync", 32'(bus.sync), 32'(exp_sync));
      check("t4_count", bus.frame_count, exp_cnt);
    end
    bus.count_clear = 1'b0;
    bus.trig        = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    check("t4_idle_timeout", 32'(bus.busy), 32'd0);
    check("t4_final_count", bus.frame_count, 32'd1);

    // 5. Asynchronous reset in the middle of FRAME_HIGH.
    tick();
    bus.trig = 1'b1;
    repeat (4) tick();
    check("t5_sync_before", 32'(bus.sync), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_sync", 32'(bus.sync), 32'd0);
    check("t5_async_busy", 32'(bus.busy), 32'd0);
    check("t5_async_count", bus.frame_count, 32'd0);
    check("t5_async_state", 32'(dbg_state), 32'd0);
    #2;
    reset_n = 1'b1;
    repeat (15) begin
      tick();
      check("t5_after_sync", 32'(bus.sync), 32'd0);
      check("t5_after_busy", 32'(bus.busy), 32'd0);
    end

`ifdef MINISCOPE_EMULATOR_JITTER_EN
    // 6. Jittered low phases against a reference LFSR.
    begin
      logic [15:0] ref_lfsr;
      int          hw;
      int          lw;
      ref_lfsr = 16'hACE1;
      bus.trig = 1'b0;
      tick();
      bus.trig = 1'b1;
      for (int f = 0; f < 20; f++) begin
        n = 0;
        while (!bus.sync && n < 40) begin
          tick();
          n++;
        end
        check("t6_rise_timeout", 32'(bus.sync), 32'd1);
        hw = 1;
        for (int k = 0; k < 40; k++) begin
          tick();
          if (!bus.sync) break;
          hw++;
        end
        check("t6_high_width", 32'(hw), 32'd4);
        ref_lfsr = lfsr_step(ref_lfsr);
        lw = 1;
        for (int k = 0; k < 60; k++) begin
          tick();
          if (bus.sync) break;
          lw++;
        end
        check("t6_low_width", 32'(lw), 32'(6 + int'(ref_lfsr[3:0])));
      end
      bus.trig = 1'b0;
      n = 0;
      while (bus.busy && n < 60) begin
        tick();
        n++;
      end
      check("t6_idle_timeout", 32'(bus.busy), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
